// File: rtl/random_word_pool_pkg.sv
// Shared defaults and helpers for the random word pool.
// Contents:
//   DEFAULT_*  - default parameter values (RATE matches the whitener RATE)
//   idx_width  - width of an index/pointer over n entries, never below 1 bit
package random_word_pool_pkg;

    localparam int unsigned DEFAULT_RATE         = 8;
    localparam int unsigned DEFAULT_WORD_WIDTH   = 32;
    localparam int unsigned DEFAULT_DEPTH        = 4;
    localparam int unsigned DEFAULT_REPEAT_LIMIT = 4;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/random_word_pool_sync_fifo.sv
// Synchronous word FIFO used by random_word_pool.
// Ports:
//   clk, rst  - clock, synchronous active-high reset (clears storage, pointers, level)
//   push      - write wr_data at the tail (ignored when full unless popping the same cycle)
//   pop       - drop the head (ignored when empty)
//   flush     - discard all content; takes priority over push/pop
//   wr_data   - word to write
//   rd_data   - word at the read pointer (stable while empty)
//   full      - level == DEPTH
//   empty     - level == 0
//   level     - words currently stored, 0..DEPTH
module random_word_pool_sync_fifo
    import random_word_pool_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WORD_WIDTH,
    parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  logic [WIDTH-1:0]           wr_data,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] level
);

    localparam int unsigned PW = idx_width(DEPTH);
    localparam int unsigned LW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             push_ok, pop_ok;

    assign full    = (level_q == LW'(DEPTH));
    assign empty   = (level_q == '0);
    assign level   = level_q;
    assign rd_data = mem_q[rd_ptr_q];

    // A push into a full FIFO is only legal when the head leaves on the same edge.
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push_ok) begin
                mem_d[wr_ptr_q] = wr_data;
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   level_d = level_q + 1'b1;
                2'b01:   level_d = level_q - 1'b1;
                default: level_d = level_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: rtl/random_word_pool.sv
// Consumer stage for the spongent entropy whitener. Accepts RATE-bit random
// chunks over the whitener's valid/received handshake, packs them LSB-first
// into WORD_WIDTH-bit words, buffers the words in a small FIFO and runs a
// repetition health check on the accepted chunk stream.
// Ports:
//   clk, rst     - clock, synchronous active-high reset
//   in_data      - random chunk from the whitener
//   in_valid     - chunk valid
//   in_received  - registered one-cycle pulse: chunk taken
//   out_data     - head-of-FIFO word (meaningful while out_valid)
//   out_valid    - FIFO non-empty and no health failure
//   out_ready    - consumer pops the head when out_valid && out_ready
//   fill_level   - words stored, 0..DEPTH
//   health_fail  - sticky alarm, cleared only by rst
module random_word_pool
    import random_word_pool_pkg::*;
#(
    parameter int unsigned RATE         = DEFAULT_RATE,
    parameter int unsigned WORD_WIDTH   = DEFAULT_WORD_WIDTH,
    parameter int unsigned DEPTH        = DEFAULT_DEPTH,
    parameter int unsigned REPEAT_LIMIT = DEFAULT_REPEAT_LIMIT
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [RATE-1:0]            in_data,
    input  logic                       in_valid,
    output logic                       in_received,
    output logic [WORD_WIDTH-1:0]      out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH+1)-1:0] fill_level,
    output logic                       health_fail
);

    localparam int unsigned CHUNKS = WORD_WIDTH / RATE;
    localparam int unsigned IW     = idx_width(CHUNKS);
    localparam int unsigned CW     = $clog2(REPEAT_LIMIT + 1);
    localparam int unsigned LW     = $clog2(DEPTH + 1);

    logic [IW-1:0]         idx_q, idx_d;
    logic [WORD_WIDTH-1:0] asm_q, asm_d;
    logic [RATE-1:0]       prev_q, prev_d;
    logic [CW-1:0]         rep_q, rep_d;
    logic                  holdoff_q, holdoff_d;
    logic                  in_received_q, in_received_d;
    logic                  health_fail_q, health_fail_d;

    logic                  accept;
    logic                  last_chunk;
    logic                  trip;
    logic                  push;
    logic                  pop;
    logic                  flush;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [WORD_WIDTH-1:0] fifo_rd_data;
    logic [LW-1:0]         fifo_level;

    assign last_chunk = (idx_q == IW'(CHUNKS - 1));
    assign out_valid  = !fifo_empty && !health_fail_q;
    assign pop        = out_valid && out_ready;

    // The last chunk of a word may only be taken if its word has somewhere to
    // go on the same edge: free space, or the head leaving this cycle.
    assign accept = in_valid && !holdoff_q && !health_fail_q &&
                    (!last_chunk || !fifo_full || pop);

    always_comb begin
        idx_d         = idx_q;
        asm_d         = asm_q;
        prev_d        = prev_q;
        rep_d         = rep_q;
        health_fail_d = health_fail_q;
        in_received_d = accept;
        // Holdoff covers the pulse cycle and the one after it, giving the
        // whitener time to drop valid before it is sampled again.
        holdoff_d     = accept || in_received_q;
        trip          = 1'b0;
        push          = 1'b0;
        if (accept) begin
            prev_d = in_data;
            // rep_q == 0 only before the first chunk after reset.
            if (rep_q != '0 && in_data == prev_q) begin
                rep_d = rep_q + 1'b1;
            end else begin
                rep_d = CW'(1);
            end
            for (int unsigned k = 0; k < CHUNKS; k++) begin
                if (idx_q == IW'(k)) begin
                    asm_d[k*RATE +: RATE] = in_data;
                end
            end
            if (rep_d == CW'(REPEAT_LIMIT)) begin
                trip          = 1'b1;
                health_fail_d = 1'b1;
            end else if (last_chunk) begin
                push = 1'b1;
            end
            idx_d = last_chunk ? '0 : idx_q + 1'b1;
        end
    end

    assign flush = trip || health_fail_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q         <= '0;
            asm_q         <= '0;
            prev_q        <= '0;
            rep_q         <= '0;
            holdoff_q     <= 1'b0;
            in_received_q <= 1'b0;
            health_fail_q <= 1'b0;
        end else begin
            idx_q         <= idx_d;
            asm_q         <= asm_d;
            prev_q        <= prev_d;
            rep_q         <= rep_d;
            holdoff_q     <= holdoff_d;
            in_received_q <= in_received_d;
            health_fail_q <= health_fail_d;
        end
    end

    random_word_pool_sync_fifo #(
        .WIDTH (WORD_WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .pop     (pop),
        .flush   (flush),
        .wr_data (asm_d),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (fifo_level)
    );

    assign in_received = in_received_q;
    assign health_fail = health_fail_q;
    assign out_data    = fifo_rd_data;
    assign fill_level  = fifo_level;

endmodule

// File: tb/tb_random_word_pool.sv
// Self-checking bench for random_word_pool: a randomized producer/consumer
// drives the design while a queue-based reference model predicts every
// output each cycle.
module tb_random_word_pool;

    localparam int unsigned RATE   = 8;
    localparam int unsigned WW     = 32;
    localparam int unsigned DEPTH  = 4;
    localparam int unsigned LIMIT  = 4;
    localparam int unsigned CHUNKS = WW / RATE;

    logic                       clk = 1'b0;
    logic                       rst = 1'b1;
    logic [RATE-1:0]            in_data = '0;
    logic                       in_valid = 1'b0;
    logic                       in_received;
    logic [WW-1:0]              out_data;
    logic                       out_valid;
    logic                       out_ready = 1'b0;
    logic [$clog2(DEPTH+1)-1:0] fill_level;
    logic                       health_fail;

    always #5 clk = ~clk;

    random_word_pool #(
        .RATE         (RATE),
        .WORD_WIDTH   (WW),
        .DEPTH        (DEPTH),
        .REPEAT_LIMIT (LIMIT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_received (in_received),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .fill_level  (fill_level),
        .health_fail (health_fail)
    );

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: a word queue, a partial word and chunk count, the
    // cycles since the last accepted chunk, and the repetition state.
    logic [WW-1:0]   m_q[$];
    logic [WW-1:0]   m_part;
    int              m_nb;
    int              m_since;
    bit              m_rcv;
    bit              m_fail;
    bit              m_have_prev;
    logic [RATE-1:0] m_prev;
    int              m_rep;

    // Producer / consumer controls.
    logic [RATE-1:0] stim[$];
    bit              p_have;
    logic [RATE-1:0] p_byte;
    int              valid_pct;
    int              ready_mode;   // 0 low, 1 high, 2 random, 3 one-cycle pulse
    int              gen_mode;     // 0 any byte, 1 small alphabet
    bit              auto_gen;

    function automatic void model_reset();
        m_q.delete();
        m_part      = '0;
        m_nb        = 0;
        m_since     = 3;
        m_rcv       = 1'b0;
        m_fail      = 1'b0;
        m_have_prev = 1'b0;
        m_prev      = '0;
        m_rep       = 0;
    endfunction

    function automatic logic [RATE-1:0] gen_byte();
        if (gen_mode == 1) begin
            case ($urandom_range(0, 2))
                0:       return 8'hAA;
                1:       return 8'hBB;
                default: return 8'hCC;
            endcase
        end
        return RATE'($urandom_range(0, 255));
    endfunction

    task automatic compare_outputs();
        bit exp_valid;
        exp_valid = (m_q.size() > 0) && !m_fail;
        check("in_received", 32'(in_received), 32'(m_rcv));
        check("health_fail", 32'(health_fail), 32'(m_fail));
        check("out_valid",   32'(out_valid),   32'(exp_valid));
        check("fill_level",  32'(fill_level),  32'(m_q.size()));
        if (exp_valid) check("out_data", out_data, m_q[0]);
    endtask

    // Choose this cycle's inputs and advance the model to the next edge.
    task automatic drive_and_step();
        bit ov, pop, last, acc;
        if (!p_have) begin
            if (stim.size() > 0) begin
                p_byte = stim.pop_front();
                p_have = 1'b1;
            end else if (auto_gen) begin
                p_byte = gen_byte();
                p_have = 1'b1;
            end
        end
        in_valid = p_have && (int'($urandom_range(0, 99)) < valid_pct);
        in_data  = p_have ? p_byte : RATE'($urandom_range(0, 255));
        case (ready_mode)
            0: out_ready = 1'b0;
            1: out_ready = 1'b1;
            2: out_ready = 1'($urandom_range(0, 1));
            default: begin
                out_ready  = 1'b1;
                ready_mode = 0;
            end
        endcase

        ov   = (m_q.size() > 0) && !m_fail;
        pop  = ov && out_ready;
        last = (m_nb == int'(CHUNKS) - 1);
        acc  = in_valid && (m_since >= 3) && !m_fail &&
               (!last || m_q.size() < int'(DEPTH) || pop);
        m_rcv = acc;
        if (pop) void'(m_q.pop_front());
        if (acc) begin
            m_rep       = (m_have_prev && in_data == m_prev) ? m_rep + 1 : 1;
            m_prev      = in_data;
            m_have_prev = 1'b1;
            if (m_rep >= int'(LIMIT)) begin
                m_fail = 1'b1;
            end else begin
                m_part[m_nb*RATE +: RATE] = in_data;
                if (last) begin
                    m_q.push_back(m_part);
                    m_nb = 0;
                end else begin
                    m_nb++;
                end
            end
            p_have = 1'b0;
        end
        if (m_fail) m_q.delete();
        if (acc) m_since = 1;
        else if (m_since < 100) m_since++;
    endtask

    task automatic run(input int n);
        repeat (n) begin
            compare_outputs();
            drive_and_step();
            @(negedge clk);
        end
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
        stim.delete();
        p_have     = 1'b0;
        ready_mode = 0;
        auto_gen   = 1'b0;
        gen_mode   = 0;
        valid_pct  = 100;
        check("rst_in_received", 32'(in_received), 32'd0);
        check("rst_out_valid",   32'(out_valid),   32'd0);
        check("rst_out_data",    out_data,         32'd0);
        check("rst_fill_level",  32'(fill_level),  32'd0);
        check("rst_health_fail", 32'(health_fail), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        p_have = 1'b0;

        // Basic packing of one word, first chunk in the LSBs.
        do_reset();
        stim = '{8'h01, 8'h02, 8'h03, 8'h04};
        run(16);
        check("s1_word",  out_data, 32'h04030201);
        check("s1_fill",  32'(fill_level), 32'd1);
        check("s1_valid", 32'(out_valid),  32'd1);

        // Fill to DEPTH with a fifth word stalled, pop once, then free-run.
        do_reset();
        for (int i = 0; i < 20; i++) stim.push_back(RATE'($urandom_range(0, 255)));
        run(80);
        check("s2_full",      32'(fill_level),  32'd4);
        check("s2_stalled",   32'(in_received), 32'd0);
        ready_mode = 3;
        run(10);
        check("s3_full_after_pop", 32'(fill_level), 32'd4);
        ready_mode = 2;
        auto_gen   = 1'b1;
        valid_pct  = 70;
        run(400);
        auto_gen   = 1'b0;
        ready_mode = 1;
        run(60);
        check("s3_drained", 32'(fill_level), 32'd0);

        // Four identical chunks trip the alarm and flush a stored word.
        do_reset();
        stim = '{8'h01, 8'h02, 8'h03, 8'h04, 8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'h55};
        run(40);
        check("s4_fail",  32'(health_fail), 32'd1);
        check("s4_valid", 32'(out_valid),   32'd0);
        check("s4_fill",  32'(fill_level),  32'd0);
        ready_mode = 1;
        run(10);

        // A differing chunk restarts the repetition count.
        do_reset();
        stim = '{8'hAA, 8'hAA, 8'hAA, 8'hBB, 8'hAA, 8'hAA, 8'hAA};
        run(30);
        check("s5_no_fail", 32'(health_fail), 32'd0);
        check("s5_fill",    32'(fill_level),  32'd1);

        // Reset in the middle of a word leaves no stale chunks behind.
        do_reset();
        stim = '{8'hE1, 8'hE2};
        run(8);
        do_reset();
        stim = '{8'h11, 8'h22, 8'h33, 8'h44};
        run(16);
        check("s6_fresh_word", out_data, 32'h44332211);
        check("s6_fill",       32'(fill_level), 32'd1);

        // Small-alphabet random streams that tend to trip the health check.
        for (int r = 0; r < 3; r++) begin
            do_reset();
            gen_mode   = 1;
            auto_gen   = 1'b1;
            valid_pct  = 80;
            ready_mode = 2;
            run(250);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
